// File: rtl/terminal_pkg.sv
// Shared constants, FSM state type and character-to-display-code helper.
package terminal_pkg;

  localparam int unsigned CHAR_W = 7;
  localparam int unsigned CODE_W = 6;

  localparam logic [CHAR_W-1:0] ASCII_CR    = 7'h0D;
  localparam logic [CHAR_W-1:0] ASCII_SPACE = 7'h20;
  localparam logic [CHAR_W-1:0] PRINT_LO    = 7'h20;
  localparam logic [CHAR_W-1:0] PRINT_HI    = 7'h5F;
  localparam logic [CHAR_W-1:0] LOWER_LO    = 7'h60;
  localparam logic [CHAR_W-1:0] LOWER_HI    = 7'h7E;

  localparam logic [CODE_W-1:0] CODE_SPACE = CODE_W'(ASCII_SPACE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_NEWLINE,
    ST_SCROLL_CLR,
    ST_CLEAR_ALL
  } state_e;

  // Display code is the low six ASCII bits; lower case folds onto upper case.
  function automatic logic [CODE_W-1:0] display_code(input logic [CHAR_W-1:0] ch);
    logic [CODE_W-1:0] code;
    code = ch[CODE_W-1:0];
    if (ch >= LOWER_LO) code[5] = 1'b0;
    return code;
  endfunction

endpackage

// File: rtl/terminal_text_engine_if.sv
// Character input handshake and screen RAM write port.
interface terminal_text_engine_if
  import terminal_pkg::*;
#(
  parameter int unsigned AW = 10
);
  logic [CHAR_W-1:0] rd_in;
  logic              da_in;
  logic              rda_out;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [CODE_W-1:0] mem_wdata;

  modport master (
    input  rd_in, da_in,
    output rda_out, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rd_in, da_in,
    input  rda_out, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/term_char_fifo.sv
// Small synchronous character FIFO with flush; full/empty are registered.
module term_char_fifo
  import terminal_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = CHAR_W
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head_c,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_idx, wr_nxt, rd_nxt;
  logic [PW:0]   count, cnt_nxt;
  logic          do_push, do_pop;

  // Flush empties the queue but still honours a push in the same cycle.
  always_comb begin
    do_push = push && (flush || !full);
    do_pop  = pop && !empty && !flush;
    wr_idx  = flush ? '0 : wr_ptr;
    wr_nxt  = wr_idx + PW'(do_push);
    rd_nxt  = flush ? '0 : (rd_ptr + PW'(do_pop));
    cnt_nxt = flush ? '0 : count;
    if (do_push) cnt_nxt = cnt_nxt + (PW+1)'(1);
    if (do_pop)  cnt_nxt = cnt_nxt - (PW+1)'(1);
  end

  // Pointer, count and status registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      full   <= (cnt_nxt == DEPTH_C);
      empty  <= (cnt_nxt == '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/terminal_text_engine.sv
// Terminal text engine: queues keyboard characters and renders them into a
// scrolling screen RAM as six-bit display codes.
module terminal_text_engine
  import terminal_pkg::*;
#(
  parameter int unsigned COLS       = 40,
  parameter int unsigned ROWS       = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   clr_btn,
  terminal_text_engine_if.master bus,
  output logic [$clog2(ROWS)-1:0] row_base,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic                   busy,
  output logic                   ovf
);

  localparam int unsigned AW = $clog2(COLS*ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);

  localparam logic [CW-1:0] COL_LAST    = CW'(COLS-1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS-1);
  localparam logic [RW:0]   ROWS_EXT    = (RW+1)'(ROWS);
  localparam logic [AW-1:0] SCROLL_LAST = AW'(COLS-1);
  localparam logic [AW-1:0] CLEAR_LAST  = AW'(COLS*ROWS-1);

  state_e            state_q, state_d;
  logic [CW-1:0]     col_d;
  logic [RW-1:0]     row_d, rb_d, rb_inc, phys_row;
  logic [RW:0]       phys_sum;
  logic [AW-1:0]     idx_q, idx_d, addr_q, addr_d, cursor_addr;
  logic [CHAR_W-1:0] ch_q, ch_d;
  logic [CODE_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d, ovf_d, rda_q;

  logic [2:0]        da_sync, clr_sync;
  logic [CHAR_W-1:0] rd_s1, rd_s2;
  logic              da_evt, clr_evt;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CHAR_W-1:0] fifo_head;

  // Double-flop synchronisers plus one history bit for rising-edge detect.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      da_sync  <= '0;
      clr_sync <= '0;
      rd_s1    <= '0;
      rd_s2    <= '0;
    end else begin
      da_sync  <= {da_sync[1:0], bus.da_in};
      clr_sync <= {clr_sync[1:0], clr_btn};
      rd_s1    <= bus.rd_in;
      rd_s2    <= rd_s1;
    end
  end

  assign da_evt  = da_sync[1] & ~da_sync[2];
  assign clr_evt = clr_sync[1] & ~clr_sync[2];

  term_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CHAR_W)
  ) u_fifo (
    .clk    (clk),
    .clr_n  (clr_n),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .flush  (clr_evt),
    .din    (rd_s2),
    .head_c (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Cursor to physical RAM address; the row wrap is a single compare-and-subtract.
  always_comb begin
    phys_sum    = {1'b0, row_base} + {1'b0, cur_row};
    phys_row    = (phys_sum >= ROWS_EXT) ? RW'(phys_sum - ROWS_EXT) : RW'(phys_sum);
    cursor_addr = AW'(phys_row) * AW'(COLS) + AW'(cur_col);
    rb_inc      = (row_base == ROW_LAST) ? '0 : (row_base + RW'(1));
  end

  // Next-state and next-output logic; a clear event overrides everything.
  always_comb begin
    state_d   = state_q;
    col_d     = cur_col;
    row_d     = cur_row;
    rb_d      = row_base;
    idx_d     = idx_q;
    ch_d      = ch_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    fifo_pop  = 1'b0;
    fifo_push = da_evt && (!fifo_full || clr_evt);
    ovf_d     = ovf || (da_evt && fifo_full && !clr_evt);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          ch_d     = fifo_head;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (ch_q == ASCII_CR) begin
          state_d = ST_NEWLINE;
        end else if (((ch_q >= PRINT_LO) && (ch_q <= PRINT_HI)) ||
                     ((ch_q >= LOWER_LO) && (ch_q <= LOWER_HI))) begin
          we_d    = 1'b1;
          addr_d  = cursor_addr;
          wdata_d = display_code(ch_q);
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (cur_col < COL_LAST) begin
          col_d   = cur_col + CW'(1);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_NEWLINE;
        end
      end
      ST_NEWLINE: begin
        col_d = '0;
        if (cur_row < ROW_LAST) begin
          row_d   = cur_row + RW'(1);
          state_d = ST_IDLE;
        end else begin
          // The old top row becomes the new bottom row and is blanked.
          rb_d    = rb_inc;
          idx_d   = '0;
          we_d    = 1'b1;
          addr_d  = AW'(row_base) * AW'(COLS);
          wdata_d = CODE_SPACE;
          state_d = ST_SCROLL_CLR;
        end
      end
      ST_SCROLL_CLR: begin
        if (idx_q < SCROLL_LAST) begin
          idx_d  = idx_q + AW'(1);
          we_d   = 1'b1;
          addr_d = addr_q + AW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR_ALL: begin
        if (idx_q < CLEAR_LAST) begin
          idx_d  = idx_q + AW'(1);
          we_d   = 1'b1;
          addr_d = addr_q + AW'(1);
        end else begin
          rb_d    = '0;
          col_d   = '0;
          row_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clr_evt) begin
      fifo_pop = 1'b0;
      ovf_d    = 1'b0;
      idx_d    = '0;
      we_d     = 1'b1;
      addr_d   = '0;
      wdata_d  = CODE_SPACE;
      state_d  = ST_CLEAR_ALL;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= ST_IDLE;
      cur_col  <= '0;
      cur_row  <= '0;
      row_base <= '0;
      idx_q    <= '0;
      ch_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      rda_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_col  <= col_d;
      cur_row  <= row_d;
      row_base <= rb_d;
      idx_q    <= idx_d;
      ch_q     <= ch_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ovf      <= ovf_d;
      busy     <= (state_d != ST_IDLE);
      rda_q    <= ~fifo_full;
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rda_out   = rda_q;

endmodule
